// File: rtl/mmuart_tx_arbiter_if.sv
// Byte handshake bundle between N requesters, the TX arbiter and one UART transmitter core.
// master = arbiter view, slave = requester/UART view.
interface mmuart_tx_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_wr;
  logic           tx_done;

  modport master (
    input  req_valid, req_data, req_last, tx_done,
    output req_ready, tx_data, tx_wr
  );

  modport slave (
    output req_valid, req_data, req_last, tx_done,
    input  req_ready, tx_data, tx_wr
  );
endinterface

// File: rtl/mmuart_tx_arbiter.sv
// Round-robin, packet-locking arbiter that shares one UART TX core among N byte requesters,
// keeping one byte in flight with an optional inter-byte gap and a tx_done watchdog.
module mmuart_tx_arbiter #(
  parameter int N          = 4,
  parameter int GAP_CYCLES = 0,
  parameter int TIMEOUT    = 1048576
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  mmuart_tx_arbiter_if.master bus,
  output logic [N-1:0]        grant,
  output logic                busy,
  output logic                timeout_err,
  output logic [1:0]          o_dbg_state
);
  // Handshakes: a requester byte moves on the edge where req_valid[k] & req_ready[k]; ready is
  // offered only in IDLE, to one requester at a time, and a waiting requester keeps its byte
  // stable. Toward the UART, tx_wr is a single-cycle strobe and the next one is held back until
  // tx_done (seen only in WAIT_DONE) or the watchdog fires.

  localparam int PTR_W   = $clog2(N);
  localparam int WD_NEED = $clog2(TIMEOUT + 1);
  localparam int WD_W    = (WD_NEED > 21) ? WD_NEED : 21;
  localparam logic [WD_W-1:0] WD_LAST  = (TIMEOUT == 0) ? '0 : WD_W'(TIMEOUT - 1);
  localparam logic [15:0]     GAP_LAST = (GAP_CYCLES == 0) ? 16'd0 : 16'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    GAP       = 2'd3
  } state_t;

  localparam state_t REST = (GAP_CYCLES == 0) ? IDLE : GAP;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PTR_W-1:0]  r_ptr;
  logic              r_lock;
  logic [7:0]        r_tx_data;
  logic [N-1:0]      r_grant;
  logic [WD_W-1:0]   r_wd_cnt;
  logic [15:0]       r_gap_cnt;
  logic              r_timeout_err;

  logic              w_found;
  logic [PTR_W-1:0]  w_sel;
  logic [PTR_W-1:0]  w_idx;
  logic              w_accept;
  logic [N-1:0]      w_onehot;
  logic [7:0]        w_sel_data;
  logic              w_wd_expire;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p, input int step);
    int s;
    s = int'(p) + step;
    if (s >= N) s = s - N;
    return PTR_W'(s);
  endfunction

  // Scan ptr+1 .. ptr+N; the owner itself (ptr) comes last, and is the only candidate when locked.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_ptr;
    w_idx   = r_ptr;
    for (int i = 1; i <= N; i++) begin
      w_idx = wrap_inc(r_ptr, i);
      if (!w_found && bus.req_valid[w_idx] && (!r_lock || (w_idx == r_ptr))) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  assign w_accept    = (r_state == IDLE) && w_found;
  assign w_onehot    = {{(N-1){1'b0}}, 1'b1} << w_sel;
  assign w_sel_data  = bus.req_data[8*w_sel +: 8];
  assign w_wd_expire = (TIMEOUT != 0) && (r_state == WAIT_DONE) && !bus.tx_done &&
                       (r_wd_cnt == WD_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (w_found) w_state_nxt = ISSUE;
      ISSUE:     w_state_nxt = WAIT_DONE;
      WAIT_DONE: if (bus.tx_done || w_wd_expire) w_state_nxt = REST;
      GAP:       if (r_gap_cnt == GAP_LAST) w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state       <= IDLE;
      r_ptr         <= PTR_W'(N - 1);
      r_lock        <= 1'b0;
      r_tx_data     <= 8'd0;
      r_grant       <= '0;
      r_wd_cnt      <= '0;
      r_gap_cnt     <= 16'd0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_timeout_err <= w_wd_expire;
      if (w_accept) begin
        r_tx_data <= w_sel_data;
        r_grant   <= w_onehot;
        r_ptr     <= w_sel;
        r_lock    <= ~bus.req_last[w_sel];
      end
      if (w_wd_expire) r_lock <= 1'b0;
      case (r_state)
        ISSUE:     r_wd_cnt  <= '0;
        WAIT_DONE: begin
          r_wd_cnt  <= r_wd_cnt + 1'b1;
          r_gap_cnt <= 16'd0;
        end
        GAP:       r_gap_cnt <= r_gap_cnt + 16'd1;
        default:   ;
      endcase
    end
  end

  assign bus.req_ready = w_accept ? w_onehot : '0;
  assign bus.tx_data   = r_tx_data;
  assign bus.tx_wr     = (r_state == ISSUE);
  assign grant         = r_grant;
  assign busy          = (r_state != IDLE);
  assign timeout_err   = r_timeout_err;
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_mmuart_tx_arbiter.sv
// Bench for mmuart_tx_arbiter: dut0 (no gap, long watchdog) and dut1 (gap 10, watchdog 100),
// directed stimulus, expected {grant, byte} queues checked by a tx_wr monitor.
module tb_mmuart_tx_arbiter;
  logic       clk = 1'b0;
  logic [1:0] rst;
  logic [3:0]  rv [2];
  logic [31:0] rd [2];
  logic [3:0]  rl [2];
  logic        resp_done0, resp_done1, stray_done0;
  logic        resp_en [2];
  int          resp_delay [2];

  logic [3:0] grant0, grant1;
  logic       busy0, busy1, terr0, terr1;
  logic [1:0] dbg0, dbg1;

  int n_cmp = 0;
  int n_err = 0;
  logic [11:0] exp_q0 [$];
  logic [11:0] exp_q1 [$];
  logic [1:0]  inflight = 2'b00;
  int          n_terr [2] = '{0, 0};

  mmuart_tx_arbiter_if #(.N(4)) bus0 ();
  mmuart_tx_arbiter_if #(.N(4)) bus1 ();

  assign bus0.req_valid = rv[0];
  assign bus0.req_data  = rd[0];
  assign bus0.req_last  = rl[0];
  assign bus0.tx_done   = resp_done0 | stray_done0;
  assign bus1.req_valid = rv[1];
  assign bus1.req_data  = rd[1];
  assign bus1.req_last  = rl[1];
  assign bus1.tx_done   = resp_done1;

  mmuart_tx_arbiter #(.N(4), .GAP_CYCLES(0), .TIMEOUT(1048576)) dut0 (
    .sys_clk(clk), .sys_rst(rst[0]), .bus(bus0),
    .grant(grant0), .busy(busy0), .timeout_err(terr0), .o_dbg_state(dbg0)
  );

  mmuart_tx_arbiter #(.N(4), .GAP_CYCLES(10), .TIMEOUT(100)) dut1 (
    .sys_clk(clk), .sys_rst(rst[1]), .bus(bus1),
    .grant(grant1), .busy(busy1), .timeout_err(terr1), .o_dbg_state(dbg1)
  );

  // ---------------- clock / global bound ----------------
  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_bound: got still running, expected finished");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int d);
    rst[d] = 1'b1;
    step();
    step();
    rst[d] = 1'b0;
  endtask

  // s: 0 tx_wr, 1 tx_done, 2 timeout_err, 3 idle, 4..7 req_ready[s-4]
  function automatic logic sig_of(input int d, input int s);
    logic [3:0] rdy;
    logic wr, dn, te, bz;
    if (d == 0) begin
      rdy = bus0.req_ready; wr = bus0.tx_wr; dn = bus0.tx_done; te = terr0; bz = busy0;
    end else begin
      rdy = bus1.req_ready; wr = bus1.tx_wr; dn = bus1.tx_done; te = terr1; bz = busy1;
    end
    case (s)
      0:       return wr;
      1:       return dn;
      2:       return te;
      3:       return !bz;
      default: return rdy[s-4];
    endcase
  endfunction

  // Returns cyc = number of negedges waited (1 = current cycle), 0 if the bound expired.
  task automatic wait_sig(input int d, input int s, input string nm, output int cyc);
    cyc = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (sig_of(d, s)) begin
        cyc = i;
        break;
      end
    end
    check({nm, "_seen"}, 32'(cyc > 0), 32'd1);
  endtask

  // ---------------- UART responders ----------------
  initial begin
    resp_done0 = 1'b0;
    forever begin
      @(negedge clk);
      if (bus0.tx_wr && resp_en[0]) begin
        repeat (resp_delay[0]) @(posedge clk);
        #1 resp_done0 = 1'b1;
        @(posedge clk);
        #1 resp_done0 = 1'b0;
      end
    end
  end

  initial begin
    resp_done1 = 1'b0;
    forever begin
      @(negedge clk);
      if (bus1.tx_wr && resp_en[1]) begin
        repeat (resp_delay[1]) @(posedge clk);
        #1 resp_done1 = 1'b1;
        @(posedge clk);
        #1 resp_done1 = 1'b0;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  task automatic mon(input int d);
    logic [11:0] got, exp;
    logic wr, dn, te, empty;
    if (d == 0) begin
      wr = bus0.tx_wr; dn = bus0.tx_done; te = terr0; got = {grant0, bus0.tx_data};
      empty = (exp_q0.size() == 0);
    end else begin
      wr = bus1.tx_wr; dn = bus1.tx_done; te = terr1; got = {grant1, bus1.tx_data};
      empty = (exp_q1.size() == 0);
    end
    if (rst[d]) begin
      inflight[d] = 1'b0;
    end else begin
      if (te) n_terr[d]++;
      if (dn || te) inflight[d] = 1'b0;
      if (wr) begin
        check($sformatf("dut%0d_tx_wr_while_in_flight", d), 32'(inflight[d]), 32'd0);
        inflight[d] = 1'b1;
        if (empty) begin
          n_cmp++;
          n_err++;
          $display("FAIL dut%0d_unexpected_tx_wr: got 0x%0h, expected no write", d, got);
        end else begin
          if (d == 0) exp = exp_q0.pop_front();
          else        exp = exp_q1.pop_front();
          check($sformatf("dut%0d_grant_byte", d), 32'(got), 32'(exp));
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int c;
    int n_acc;
    int cnt;
    rst         = 2'b11;
    rv          = '{4'd0, 4'd0};
    rd          = '{32'd0, 32'd0};
    rl          = '{4'd0, 4'd0};
    stray_done0 = 1'b0;
    resp_en     = '{1'b0, 1'b0};
    resp_delay  = '{4, 4};

    // Reset values
    do_reset(0);
    @(negedge clk);
    check("rst_grant", grant0, 4'b0000);
    check("rst_busy", busy0, 1'b0);
    check("rst_timeout_err", terr0, 1'b0);
    check("rst_req_ready", bus0.req_ready, 4'b0000);
    check("rst_tx_wr", bus0.tx_wr, 1'b0);
    check("rst_tx_data", bus0.tx_data, 8'h00);
    check("rst_dbg_state", dbg0, 2'd0);

    // 1. Single byte, tx_done 160 cycles after tx_wr
    step();
    resp_en[0] = 1'b1;
    resp_delay[0] = 160;
    rv[0] = 4'b0001; rd[0][7:0] = 8'h41; rl[0] = 4'b0001;
    exp_q0.push_back({4'b0001, 8'h41});
    @(negedge clk);
    check("t1_ready_same_cycle", bus0.req_ready, 4'b0001);
    step();
    rv[0] = 4'b0000;
    @(negedge clk);
    check("t1_tx_wr_next_cycle", bus0.tx_wr, 1'b1);
    check("t1_tx_data", bus0.tx_data, 8'h41);
    wait_sig(0, 1, "t1_tx_done", c);
    check("t1_busy_at_done", busy0, 1'b1);
    @(negedge clk);
    check("t1_busy_after_done", busy0, 1'b0);
    check("t1_grant", grant0, 4'b0001);
    check("t1_tx_data_held", bus0.tx_data, 8'h41);

    // 2. Round robin with all four valid
    do_reset(0);
    resp_delay[0] = 4;
    rv[0] = 4'b1111; rd[0] = 32'h40302010; rl[0] = 4'b1111;
    exp_q0.push_back({4'b0001, 8'h10});
    exp_q0.push_back({4'b0010, 8'h20});
    exp_q0.push_back({4'b0100, 8'h30});
    exp_q0.push_back({4'b1000, 8'h40});
    exp_q0.push_back({4'b0001, 8'h10});
    n_acc = 0;
    for (int i = 0; i < 300 && n_acc < 5; i++) begin
      @(negedge clk);
      if (bus0.req_ready != 4'b0000) begin
        check("t2_ready_onehot", $countones(bus0.req_ready), 1);
        n_acc++;
      end
    end
    check("t2_accept_count", n_acc, 5);
    step();
    rv[0] = 4'b0000;
    wait_sig(0, 3, "t2_idle", c);
    check("t2_queue_drained", exp_q0.size(), 0);

    // 3. Packet lock: req1 sends A1,A2,A3 while req2 waits
    do_reset(0);
    rv[0] = 4'b0110; rd[0] = 32'h00B2A100; rl[0] = 4'b0100;
    exp_q0.push_back({4'b0010, 8'hA1});
    exp_q0.push_back({4'b0010, 8'hA2});
    exp_q0.push_back({4'b0010, 8'hA3});
    exp_q0.push_back({4'b0100, 8'hB2});
    wait_sig(0, 5, "t3_a1_ready", c);
    step();
    rd[0][15:8] = 8'hA2;
    wait_sig(0, 5, "t3_a2_ready", c);
    step();
    rv[0][1] = 1'b0;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus0.req_ready != 4'b0000) cnt++;
    end
    check("t3_no_grant_while_locked", cnt, 0);
    check("t3_idle_while_locked", busy0, 1'b0);
    check("t3_grant_held", grant0, 4'b0010);
    step();
    rv[0][1] = 1'b1; rd[0][15:8] = 8'hA3; rl[0][1] = 1'b1;
    wait_sig(0, 5, "t3_a3_ready", c);
    check("t3_a3_immediate", c, 1);
    step();
    rv[0][1] = 1'b0;
    wait_sig(0, 6, "t3_b_ready", c);
    step();
    rv[0][2] = 1'b0;
    wait_sig(0, 3, "t3_idle", c);
    check("t3_queue_drained", exp_q0.size(), 0);

    // 6. Reset during WAIT_DONE, then a stray tx_done
    do_reset(0);
    resp_en[0] = 1'b0;
    rv[0] = 4'b0100; rd[0] = 32'h005A0000; rl[0] = 4'b0000;
    exp_q0.push_back({4'b0100, 8'h5A});
    wait_sig(0, 6, "t6_ready", c);
    step();
    rv[0] = 4'b0000;
    wait_sig(0, 0, "t6_tx_wr", c);
    repeat (5) @(negedge clk);
    step();
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    @(negedge clk);
    check("t6_busy_after_rst", busy0, 1'b0);
    check("t6_grant_after_rst", grant0, 4'b0000);
    check("t6_tx_wr_after_rst", bus0.tx_wr, 1'b0);
    check("t6_tx_data_after_rst", bus0.tx_data, 8'h00);
    step();
    stray_done0 = 1'b1;
    step();
    stray_done0 = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus0.tx_wr || busy0) cnt++;
    end
    check("t6_stray_done_ignored", cnt, 0);
    step();
    resp_en[0] = 1'b1;
    rv[0] = 4'b0010; rd[0] = 32'h00007700; rl[0] = 4'b0010;
    exp_q0.push_back({4'b0010, 8'h77});
    wait_sig(0, 5, "t6_lock_cleared_ready", c);
    check("t6_lock_cleared_immediate", c, 1);
    step();
    rv[0] = 4'b0000;
    wait_sig(0, 3, "t6_idle", c);

    // 4. Gap of 10 cycles (dut1)
    do_reset(1);
    @(negedge clk);
    check("t4_rst_dbg_state", dbg1, 2'd0);
    step();
    resp_en[1] = 1'b1;
    resp_delay[1] = 20;
    rv[1] = 4'b0011; rd[1] = 32'h0000C1C0; rl[1] = 4'b0011;
    exp_q1.push_back({4'b0001, 8'hC0});
    exp_q1.push_back({4'b0010, 8'hC1});
    wait_sig(1, 4, "t4_first_ready", c);
    check("t4_first_ready_same_cycle", c, 1);
    step();
    rv[1][0] = 1'b0;
    wait_sig(1, 1, "t4_tx_done", c);
    @(negedge clk);
    check("t4_busy_in_gap", busy1, 1'b1);
    wait_sig(1, 5, "t4_second_ready", c);
    check("t4_gap_cycles", c, 10);
    step();
    rv[1] = 4'b0000;
    wait_sig(1, 3, "t4_idle", c);

    // 5. Watchdog with req0 locked and req3 pending (dut1)
    do_reset(1);
    resp_en[1] = 1'b0;
    rv[1] = 4'b1001; rd[1] = 32'hD30000D0; rl[1] = 4'b1000;
    exp_q1.push_back({4'b0001, 8'hD0});
    exp_q1.push_back({4'b1000, 8'hD3});
    wait_sig(1, 4, "t5_req0_ready", c);
    step();
    rv[1] = 4'b1000;
    wait_sig(1, 0, "t5_tx_wr", c);
    wait_sig(1, 2, "t5_timeout_err", c);
    check("t5_timeout_latency", c, 101);
    @(negedge clk);
    check("t5_timeout_one_cycle", terr1, 1'b0);
    resp_en[1] = 1'b1;
    wait_sig(1, 7, "t5_req3_ready", c);
    check("t5_req3_after_gap", c, 9);
    step();
    rv[1] = 4'b0000;
    wait_sig(1, 3, "t5_idle", c);

    // End-of-run bookkeeping
    check("dut0_queue_drained", exp_q0.size(), 0);
    check("dut1_queue_drained", exp_q1.size(), 0);
    check("dut0_timeout_pulses", n_terr[0], 0);
    check("dut1_timeout_pulses", n_terr[1], 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mmuart_tx_arbiter.md
Name: mmuart_tx_arbiter

Overview:
- Shares one UART transmitter core among N byte-stream requesters, e.g. debug console, monitor and bootloader.
- Sits between the requesters and the UART's tx_data/tx_wr/tx_done interface.
- Round-robin arbitration at byte granularity, with optional packet locking so multi-byte messages are not interleaved.
- Enforces one byte in flight, an optional inter-byte gap, and a tx_done watchdog.

Parameters:
- N, 4, number of requesters (2..8).
- GAP_CYCLES, 0, idle sys_clk cycles inserted after each tx_done before the next grant (0..65535).
- TIMEOUT, 1048576, max sys_clk cycles to wait for tx_done after tx_wr; 0 disables the watchdog.

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  synchronous active-high reset
- req_valid  in  N  requester k has a byte
- req_data  in  8*N  byte of requester k at bits [8k+7:8k]
- req_last  in  N  byte is last of packet (1 = release lock)
- req_ready  out  N  one-hot accept strobe; byte taken on the edge where valid&ready
- tx_data  out  8  byte to UART core
- tx_wr  out  1  one-cycle write strobe to UART core
- tx_done  in  1  one-cycle completion pulse from UART core
- grant  out  N  one-hot current/last owner (0 after reset)
- busy  out  1  state != IDLE
- timeout_err  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Reset values:
  - state=IDLE; tx_wr=0; tx_data=0; grant=0; timeout_err=0; lock=0.
  - RR pointer=N-1, so requester 0 has first priority.
  - req_ready=0, since it is combinational and only asserted in IDLE.
- FSM states: IDLE, ISSUE, WAIT_DONE, GAP.
- IDLE:
  - Candidate set: if lock=1, only the locked owner; otherwise all requesters.
  - Select the first valid candidate scanning ptr+1, ptr+2, … modulo N.
  - req_ready[sel]=1 combinationally in that same cycle.
  - On the edge: latch byte into tx_data; grant=onehot(sel); ptr=sel; lock=~req_last[sel]; go to ISSUE.
  - No valid candidate: stay in IDLE, req_ready=0.
- ISSUE: tx_wr=1 for exactly this one cycle; go to WAIT_DONE and clear the watchdog counter.
- Latency: valid seen in IDLE cycle T → req_ready in cycle T → tx_wr in cycle T+1.
- WAIT_DONE:
  - tx_done=1 → go to GAP, or to IDLE if GAP_CYCLES=0. Next grant is possible in the cycle after tx_done.
  - Watchdog: counter increments each cycle. When it reaches TIMEOUT-1 without tx_done (TIMEOUT≠0): pulse timeout_err next cycle, clear lock, go to GAP/IDLE as above.
- GAP: count GAP_CYCLES cycles, then go to IDLE. First possible req_ready is GAP_CYCLES cycles after leaving WAIT_DONE.
- tx_done outside WAIT_DONE is ignored; tx_wr is never reasserted before tx_done or timeout.
- Lock:
  - Held across any number of idle cycles.
  - Non-owner valids stall while lock=1.
  - Cleared only by an accepted req_last=1 byte, a timeout, or sys_rst.
- tx_data holds its value until the next accept.
- The RR pointer advances only on accept; a locked owner keeps its priority.
- Simultaneous valids: exactly one req_ready is asserted; the others wait without loss, and their data must remain stable (requester's obligation).
- sys_rst mid-operation:
  - Return immediately to reset values.
  - The in-flight byte is abandoned; a late tx_done arriving in IDLE is ignored.
- Counter widths: watchdog 21 bits minimum, sized from TIMEOUT; gap counter 16 bits.

Test Plan:
1. Single byte: req_valid=4'b0001, data 0x41, last=1 → req_ready[0] same cycle, tx_wr one cycle later with tx_data=0x41. Model tx_done 160 cycles later; busy falls the cycle after tx_done; grant=4'b0001.
2. Round-robin: all four valid continuously, last=1, data 0x10/0x20/0x30/0x40 → UART receives 0x10,0x20,0x30,0x40,0x10 in that order; exactly one tx_wr per tx_done.
3. Packet lock: req1 sends 3 bytes (last=0,0,1) while req2 is valid throughout → bytes of req1 go out contiguously, then req2. Deassert req1 valid for 50 cycles mid-packet → req2 is still not granted.
4. Gap: GAP_CYCLES=10, two requesters valid → req_ready for the second byte exactly 10 cycles after the cycle following tx_done.
5. Watchdog: TIMEOUT=100, tx_done never returned, req0 locked (last=0) → timeout_err pulse exactly once, about 100 cycles after tx_wr. Lock is cleared; a pending req3 is granted next.
6. Reset mid-WAIT_DONE: assert sys_rst for 1 cycle → busy=0, grant=0, tx_wr=0. A stray tx_done afterwards causes no tx_wr and no state change.
